spi_regfile_peripheral: RTL and testbench

//   Parametrised SPI mode-0 peripheral (successor of the fixed 5x8-bit write-only block).

---
 rtl/spi_regfile_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_regfile_peripheral.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regfile_pkg
//  Description : Shared FSM state encoding, frame field constants and the
//                frame-width helper for the SPI register-file peripheral.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_regfile_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchroniser for an asynchronous pin, followed by
//                single-cycle rising and falling edge pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta_q;
    logic r_sync_q;
    logic r_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_meta_q <= i_async;
            r_sync_q <= r_meta_q;
            r_prev_q <= r_sync_q;
        end
    end

    assign o_level = r_sync_q;
    assign o_rise  = r_sync_q & ~r_prev_q;
    assign o_fall  = ~r_sync_q & r_prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : spi_regfile_peripheral
//  Description : SPI mode-0 peripheral decoding {rw, addr, data} frames into a
//                register file, with write strobes and frame-error pulses.
//                Define SPI_READ_EN to enable register readback on CIPO.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_sclk,
    input  logic                         spi_copi,
    input  logic                         spi_ncs,
    output logic                         spi_cipo,
    output logic                         spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_copi;
    logic       w_ncs_rise;
    logic       w_ncs_fall;
    logic       w_sclk_level_unused;
    logic       w_ncs_level_unused;
    logic [1:0] w_copi_edges_unused;

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge u_sync_copi (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_copi),
        .o_level (w_copi),
        .o_rise  (w_copi_edges_unused[0]),
        .o_fall  (w_copi_edges_unused[1])
    );

    spi_sync_edge u_sync_ncs (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_ncs),
        .o_level (w_ncs_level_unused),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    state_t              r_state_q, w_state_d;
    logic [CNT_W-1:0]    r_count_q, w_count_d;
    logic [FRAME_W-1:0]  r_shift_q, w_shift_d;
    logic [DATA_W-1:0]   r_regs_q [NUM_REGS];
    logic [DATA_W-1:0]   w_regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe_q, w_wr_strobe_d;
    logic                r_frame_err_q, w_frame_err_d;

    // Field decode of the completed frame; rw ends up in the MSB.
    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_addr_ok;

    assign w_rw      = r_shift_q[FRAME_W-1];
    assign w_addr    = r_shift_q[DATA_W +: ADDR_W];
    assign w_data    = r_shift_q[DATA_W-1:0];
    assign w_addr_ok = (32'(w_addr) < NUM_REGS);

    always_comb begin
        w_state_d     = r_state_q;
        w_count_d     = r_count_q;
        w_shift_d     = r_shift_q;
        w_regs_d      = r_regs_q;
        w_wr_strobe_d = '0;
        w_frame_err_d = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_state_d = ST_SHIFT;
                    w_count_d = '0;
                    w_shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (w_sclk_rise) begin
                    if (r_count_q < CNT_FULL) begin
                        w_shift_d = {r_shift_q[FRAME_W-2:0], w_copi};
                        w_count_d = r_count_q + 1'b1;
                    end else begin
                        w_count_d = CNT_OVER;
                    end
                end
                if (w_ncs_rise) begin
                    w_state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (r_count_q != CNT_FULL) begin
                    w_frame_err_d = 1'b1;
                end else if (w_rw == RW_WRITE && w_addr_ok) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_addr == ADDR_W'(i)) begin
                            w_regs_d[i]      = w_data;
                            w_wr_strobe_d[i] = 1'b1;
                        end
                    end
                end
                if (w_ncs_fall) begin
                    w_state_d = ST_SHIFT;
                    w_count_d = '0;
                    w_shift_d = '0;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_count_q     <= '0;
            r_shift_q     <= '0;
            r_wr_strobe_q <= '0;
            r_frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= '0;
            end
        end else begin
            r_state_q     <= w_state_d;
            r_count_q     <= w_count_d;
            r_shift_q     <= w_shift_d;
            r_wr_strobe_q <= w_wr_strobe_d;
            r_frame_err_q <= w_frame_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= w_regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = r_regs_q[g];
    end

    assign wr_strobe = r_wr_strobe_q;
    assign frame_err = r_frame_err_q;

`ifdef SPI_READ_EN
    localparam logic [CNT_W-1:0] CNT_PRE_HDR = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_HDR     = CNT_W'(1 + ADDR_W);

    logic [DATA_W-1:0] r_tx_q, w_tx_d;
    logic              r_oe_q, w_oe_d;
    logic              w_hdr_rw;
    logic [ADDR_W-1:0] w_hdr_addr;

    // Header bits sit at the bottom of the shift register as the last addr bit lands.
    assign w_hdr_rw   = w_shift_d[ADDR_W];
    assign w_hdr_addr = w_shift_d[ADDR_W-1:0];

    always_comb begin
        w_tx_d = r_tx_q;
        w_oe_d = r_oe_q;
        if (r_state_q == ST_COMMIT) begin
            w_oe_d = 1'b0;
        end else if (r_state_q == ST_SHIFT) begin
            if (w_sclk_rise && r_count_q == CNT_PRE_HDR && w_hdr_rw == RW_READ) begin
                w_oe_d = 1'b1;
                w_tx_d = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_hdr_addr == ADDR_W'(i)) begin
                        w_tx_d = r_regs_q[i];
                    end
                end
            end else if (w_sclk_fall && r_oe_q && r_count_q > CNT_HDR) begin
                // The falling edge right after the header keeps the data MSB on the pin.
                w_tx_d = {r_tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_q <= '0;
            r_oe_q <= 1'b0;
        end else begin
            r_tx_q <= w_tx_d;
            r_oe_q <= w_oe_d;
        end
    end

    assign spi_cipo    = r_oe_q & r_tx_q[DATA_W-1];
    assign spi_cipo_oe = r_oe_q;
`else
    logic w_sclk_fall_unused;
    assign w_sclk_fall_unused = w_sclk_fall;
    assign spi_cipo           = 1'b0;
    assign spi_cipo_oe        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_regfile_peripheral
//  Description : Drives SPI frames into a default and a 16x16-bit instance and
//                compares against a register-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_regfile_peripheral;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sclk;
    logic [1:0] copi;
    logic [1:0] ncs;

    logic         cipo_a, oe_a, err_a;
    logic [39:0]  regs_a;
    logic [4:0]   strobe_a;
    logic         cipo_b, oe_b, err_b;
    logic [255:0] regs_b;
    logic [15:0]  strobe_b;

    always #5 clk = ~clk;

    spi_regfile_peripheral u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (sclk[0]),
        .spi_copi    (copi[0]),
        .spi_ncs     (ncs[0]),
        .spi_cipo    (cipo_a),
        .spi_cipo_oe (oe_a),
        .regs_out    (regs_a),
        .wr_strobe   (strobe_a),
        .frame_err   (err_a)
    );

    spi_regfile_peripheral #(
        .NUM_REGS (16),
        .ADDR_W   (4),
        .DATA_W   (16)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (sclk[1]),
        .spi_copi    (copi[1]),
        .spi_ncs     (ncs[1]),
        .spi_cipo    (cipo_b),
        .spi_cipo_oe (oe_b),
        .regs_out    (regs_b),
        .wr_strobe   (strobe_b),
        .frame_err   (err_b)
    );

    int nregs [2] = '{5, 16};
    int aw    [2] = '{7, 4};
    int dw    [2] = '{8, 16};

    logic [31:0] model [2][16];
    int          n_cmp = 0;
    int          n_mis = 0;

    int          err_pulses    [2];
    logic [15:0] strobe_seen   [2];
    int          strobe_cycles [2];

    always @(negedge clk) begin
        if (err_a) err_pulses[0]++;
        if (err_b) err_pulses[1]++;
        strobe_seen[0]   |= 16'(strobe_a);
        strobe_seen[1]   |= strobe_b;
        strobe_cycles[0] += $countones(strobe_a);
        strobe_cycles[1] += $countones(strobe_b);
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] expected_regs(input int w);
        logic [255:0] v = '0;
        for (int i = 0; i < nregs[w]; i++)
            for (int b = 0; b < dw[w]; b++)
                v[i*dw[w] + b] = model[w][i][b];
        return v;
    endfunction

    function automatic logic [255:0] observed_regs(input int w);
        return (w == 0) ? 256'(regs_a) : regs_b;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 16; i++)
                model[w][i] = '0;
    endtask

    task automatic wait_half();
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 frame: COPI set while SCLK low, CIPO sampled just before each rising edge.
    task automatic send_frame(input int w, input logic [63:0] frame, input int nbits,
                              output logic [63:0] cipo_bits, output int oe_hi);
        cipo_bits = '0;
        oe_hi     = 0;
        ncs[w]    = 1'b0;
        wait_half();
        for (int b = nbits - 1; b >= 0; b--) begin
            copi[w] = frame[b];
            wait_half();
            cipo_bits = {cipo_bits[62:0], (w == 0) ? cipo_a : cipo_b};
            if ((w == 0) ? oe_a : oe_b) oe_hi++;
            sclk[w] = 1'b1;
            wait_half();
            sclk[w] = 1'b0;
        end
        wait_half();
        ncs[w]  = 1'b1;
        copi[w] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_frame(input int w, input int rw, input int addr, input logic [31:0] data,
                            input int nbits, input string tag);
        int          fw = 1 + aw[w] + dw[w];
        logic [63:0] frame;
        logic [63:0] cipo_bits;
        logic [63:0] dmask;
        logic [31:0] rd_exp;
        logic [15:0] exp_strobe = '0;
        int          exp_err;
        int          oe_hi;

        dmask   = (64'd1 << dw[w]) - 64'd1;
        frame   = (64'(rw) << (aw[w] + dw[w])) | (64'(addr) << dw[w]) | (64'(data) & dmask);
        frame  |= 64'($urandom) << fw;
        rd_exp  = (addr < nregs[w]) ? model[w][addr] : 32'd0;
        exp_err = (nbits != fw) ? 1 : 0;
        if (exp_err == 0 && rw == 1 && addr < nregs[w]) begin
            model[w][addr] = data & 32'(dmask);
            exp_strobe     = 16'd1 << addr;
        end

        err_pulses[w]    = 0;
        strobe_seen[w]   = '0;
        strobe_cycles[w] = 0;
        send_frame(w, frame, nbits, cipo_bits, oe_hi);
        check_eq({tag, "_regs"}, observed_regs(w), expected_regs(w));
        repeat (4) @(negedge clk);
        check_eq({tag, "_err"}, 256'(err_pulses[w]), 256'(exp_err));
        check_eq({tag, "_strobe"}, 256'(strobe_seen[w]), 256'(exp_strobe));
        check_eq({tag, "_strobe_len"}, 256'(strobe_cycles[w]), 256'($countones(exp_strobe)));
        check_eq({tag, "_oe_idle"}, 256'((w == 0) ? oe_a : oe_b), 256'(0));
`ifdef SPI_READ_EN
        if (exp_err == 0 && rw == 0) begin
            check_eq({tag, "_rdata"}, 256'(cipo_bits & dmask), 256'(rd_exp));
            check_eq({tag, "_oe_bits"}, 256'(oe_hi), 256'(dw[w]));
        end else if (exp_err == 0) begin
            check_eq({tag, "_oe_bits"}, 256'(oe_hi), 256'(0));
        end
`else
        check_eq({tag, "_cipo"}, 256'(cipo_bits), 256'(0));
        check_eq({tag, "_oe_bits"}, 256'(oe_hi), 256'(0));
        if (rd_exp == 32'hFFFF_FFFF) $display("unreachable read value");
`endif
    endtask

    task automatic random_frame(input int w, input string tag);
        int fw   = 1 + aw[w] + dw[w];
        int rw   = int'($urandom_range(0, 1));
        int addr = int'($urandom_range(0, (1 << aw[w]) - 1));
        int nb   = fw;
        if ($urandom_range(0, 3) != 0) addr = int'($urandom_range(0, nregs[w] - 1));
        if ($urandom_range(0, 5) == 0) nb = int'($urandom_range(0, fw + 3));
        do_frame(w, rw, addr, $urandom, nb, tag);
    endtask

    initial begin
        rst  = 1'b1;
        sclk = 2'b00;
        copi = 2'b00;
        ncs  = 2'b11;
        clear_model();
        repeat (3) @(negedge clk);
        check_eq("rst_regs_a", observed_regs(0), 256'(0));
        check_eq("rst_regs_b", observed_regs(1), 256'(0));
        check_eq("rst_outs_a", 256'({strobe_a, err_a, cipo_a, oe_a}), 256'(0));
        check_eq("rst_outs_b", 256'({strobe_b, err_b, cipo_b, oe_b}), 256'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);

        do_frame(0, 1, 8'h02, 32'hA5, 16, "t1_write");
        do_frame(0, 1, 8'h05, 32'h33, 16, "t2_oob");
        do_frame(0, 1, 8'h01, 32'h5A, 12, "t3_short");
        do_frame(0, 1, 8'h01, 32'h5A, 17, "t3_long");
        do_frame(0, 0, 8'h02, 32'h00, 16, "t4_read");

        // Reset lands after 10 bits of 0x84FF; the partial frame must leave no trace.
        begin
            logic [15:0] part = 16'h84FF;
            ncs[0] = 1'b0;
            wait_half();
            for (int b = 15; b >= 6; b--) begin
                copi[0] = part[b];
                wait_half();
                sclk[0] = 1'b1;
                wait_half();
                sclk[0] = 1'b0;
            end
            rst     = 1'b1;
            ncs[0]  = 1'b1;
            copi[0] = 1'b0;
            clear_model();
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            check_eq("t5_after_rst", observed_regs(0), 256'(0));
        end
        do_frame(0, 1, 8'h04, 32'h10, 16, "t5_write");

        for (int k = 0; k < 20; k++) random_frame(0, "rnd_a");

        for (int a = 0; a < 16; a++) do_frame(1, 1, a, $urandom, 21, "t6_write");
        for (int a = 0; a < 16; a++) do_frame(1, 0, a, 32'd0, 21, "t6_read");
        for (int k = 0; k < 8; k++) random_frame(1, "rnd_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
